// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the bitstream layer, neuron and decoder blocks.
package bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    HOLD   = 2'd3
  } decoder_state_t;

  function automatic int window_len(input int bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/ones_counter.sv
// Per-channel ones counter: synchronous clear, counts i_bit while enabled.
module ones_counter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && i_bit) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/layer_decoder.sv
// Converts CHANNEL_COUNT stochastic bitstreams into ones-counts over a fixed window,
// with a start / valid-ready handshake around each measurement.
//  state  | meaning
//  IDLE   | waiting for start, last result still on result_value
//  SETTLE | discarding SETTLE_CYCLES samples while upstream streams stabilise
//  COUNT  | accumulating 2**WINDOW_BITS samples, then one cycle to latch the result
//  HOLD   | result_valid high until result_ready
module layer_decoder
  import bitstream_pkg::*;
#(
  parameter int CHANNEL_COUNT = 2,
  parameter int WINDOW_BITS   = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic                                     start,
  input  logic [CHANNEL_COUNT-1:0]                 stream_in,
  output logic                                     busy,
  output logic                                     result_valid,
  input  logic                                     result_ready,
  output logic [CHANNEL_COUNT-1:0][WINDOW_BITS:0]  result_value
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [WINDOW_BITS:0] WIN_TC = (WINDOW_BITS + 1)'(window_len(WINDOW_BITS));
  localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  decoder_state_t r_state;
  decoder_state_t w_next;
  logic           w_clear;
  logic           w_en;
  logic           w_done;

  logic [SW-1:0]                          r_settle_cnt;
  logic [WINDOW_BITS:0]                   r_win_cnt;
  logic [CHANNEL_COUNT-1:0][WINDOW_BITS:0] r_result;
  logic [CHANNEL_COUNT-1:0][WINDOW_BITS:0] w_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_en    = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = (SETTLE_CYCLES > 0) ? SETTLE : COUNT;
        end
      end
      SETTLE: begin
        if (r_settle_cnt == '0) w_next = COUNT;
      end
      COUNT: begin
        // the cycle after the last sample latches the counters
        if (r_win_cnt == WIN_TC) begin
          w_done = 1'b1;
          w_next = HOLD;
        end else begin
          w_en = 1'b1;
        end
      end
      HOLD: begin
        if (result_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
      r_result     <= '0;
    end else begin
      if (w_clear) begin
        r_settle_cnt <= SETTLE_LOAD;
        r_win_cnt    <= '0;
      end else begin
        if (r_state == SETTLE && r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - SW'(1);
        if (w_en) r_win_cnt <= r_win_cnt + (WINDOW_BITS + 1)'(1);
      end
      if (w_done) r_result <= w_cnt;
    end
  end

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_chan
    ones_counter #(
      .WIDTH(WINDOW_BITS + 1)
    ) u_cnt (
      .clk    (clk),
      .n_rst  (n_rst),
      .i_clear(w_clear),
      .i_en   (w_en),
      .i_bit  (stream_in[g]),
      .o_count(w_cnt[g])
    );
  end

  assign busy         = (r_state == SETTLE) || (r_state == COUNT);
  assign result_valid = (r_state == HOLD);
  assign result_value = r_result;

endmodule

// File: tb/tb_layer_decoder.sv
// Bench for layer_decoder: table of window patterns through a result scoreboard,
// plus hand sequences for hold, restart, mid-window reset and the no-settle build.
module tb_layer_decoder;

  localparam int CH = 2;
  localparam int WB = 4;
  localparam int ST = 2;
  localparam int NW = 16;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic [CH-1:0]     stream_in = '0;
  logic              busy;
  logic              result_valid;
  logic              result_ready = 1'b0;
  logic [CH-1:0][WB:0] result_value;

  logic              start0 = 1'b0;
  logic [CH-1:0]     stream0 = '0;
  logic              busy0;
  logic              valid0;
  logic              ready0 = 1'b0;
  logic [CH-1:0][WB:0] value0;

  always #5 clk = ~clk;

  layer_decoder #(.CHANNEL_COUNT(CH), .WINDOW_BITS(WB), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stream_in(stream_in), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready), .result_value(result_value));

  layer_decoder #(.CHANNEL_COUNT(CH), .WINDOW_BITS(WB), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .start(start0), .stream_in(stream0), .busy(busy0),
    .result_valid(valid0), .result_ready(ready0), .result_value(value0));

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [1:0]  settle_bits;
    int          e0;
    int          e1;
  } vec_t;

  typedef struct {
    int c0;
    int c1;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // start, settle, then drive one 16-sample window; restart_at pulses start mid-window
  task automatic drive_window(input logic [15:0] p0, input logic [15:0] p1,
                              input logic [1:0] sbits, input int restart_at,
                              input int e0, input int e1);
    exp_t e;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; stream_in = sbits;
    chk("busy_in_settle", int'(busy), 1);
    repeat (ST - 1) @(negedge clk);
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      stream_in = {p1[i], p0[i]};
      start = (i == restart_at);
    end
    @(negedge clk);
    stream_in = '0; start = 1'b0;
    e.c0 = e0; e.c1 = e1;
    sb.push_back(e);
    chk("valid_not_early", int'(result_valid), 0);
    chk("busy_last_cycle", int'(busy), 1);
  endtask

  task automatic wait_result(input string nm);
    int   n;
    exp_t e;
    n = 0;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, 1);
    chk({nm, "_busy_in_hold"}, int'(busy), 0);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_ch0"}, int'(result_value[0]), e.c0);
      chk({nm, "_ch1"}, int'(result_value[1]), e.c1);
    end
  endtask

  task automatic ack(input logic with_start);
    @(negedge clk); result_ready = 1'b1; start = with_start;
    @(negedge clk); result_ready = 1'b0; start = 1'b0;
    chk("valid_drop", int'(result_valid), 0);
    chk("busy_after_ack", int'(busy), 0);
    @(negedge clk);
    chk("idle_after_ack", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [CH-1:0][WB:0] held;
    bit stable;
    vecs[0] = '{16'hFFFF, 16'hFFFF, 2'b11, 16, 16};
    vecs[1] = '{16'h5555, 16'h0000, 2'b11,  8,  0};
    vecs[2] = '{16'h0000, 16'h0001, 2'b11,  0,  1};
    vecs[3] = '{16'h8000, 16'h7FFF, 2'b00,  1, 15};
    vecs[4] = '{16'h0F0F, 16'hFFFE, 2'b10,  8, 15};

    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_value", int'(result_value), 0);
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      drive_window(vecs[v].p0, vecs[v].p1, vecs[v].settle_bits, -1, vecs[v].e0, vecs[v].e1);
      wait_result($sformatf("vec%0d", v));
      ack(1'b0);
    end

    // HOLD with ready low for 10 cycles
    drive_window(16'h00FF, 16'h0FFF, 2'b11, -1, 8, 12);
    wait_result("hold");
    held = result_value;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!result_valid || result_value !== held || busy) stable = 1'b0;
    end
    chk("hold_stable", int'(stable), 1);
    ack(1'b0);

    // start during COUNT ignored, start with ready in HOLD does not restart
    drive_window(16'hFFFF, 16'hFFFF, 2'b11, 5, 16, 16);
    wait_result("restart_count");
    ack(1'b1);
    drive_window(16'h0003, 16'h0000, 2'b11, -1, 2, 0);
    wait_result("fresh");
    ack(1'b0);

    // async reset at cycle 8 of COUNT
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; stream_in = 2'b11;
    repeat (ST + 8) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(result_valid), 0);
    chk("midrst_value", int'(result_value), 0);
    @(negedge clk); n_rst = 1'b1; stream_in = '0;
    chk("midrst_idle", int'(busy), 0);
    drive_window(vecs[0].p0, vecs[0].p1, 2'b00, -1, 16, 16);
    wait_result("post_rst");
    ack(1'b0);
    chk("sb_drained", sb.size(), 0);

    // no-settle build: stream 01
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; stream0 = 2'b01;
    chk("s0_busy", int'(busy0), 1);
    repeat (NW - 1) @(negedge clk);
    @(negedge clk); stream0 = '0;
    chk("s0_not_early", int'(valid0), 0);
    @(negedge clk);
    chk("s0_valid", int'(valid0), 1);
    chk("s0_ch0", int'(value0[0]), 16);
    chk("s0_ch1", int'(value0[1]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
